// File: rtl/isa_video_regs_pkg.sv
// Shared constants for the ISA video register front end: I/O offsets,
// status byte layout and the memory wait-state FSM encoding.
package isa_video_regs_pkg;

  localparam logic [3:0] OFS_CONTROL = 4'h8;
  localparam logic [3:0] OFS_COLOR   = 4'h9;
  localparam logic [3:0] OFS_INDEX   = 4'hA;
  localparam logic [3:0] OFS_DATA    = 4'hE;

  // Tandy indexed register holding the border colour
  localparam logic [3:0] IDX_BORDER  = 4'h2;

  localparam logic [3:0] STATUS_HI   = 4'hF;
  localparam logic [1:0] STATUS_MID  = 2'b10;

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_W1,
    WS_W2,
    WS_DONE
  } wait_state_e;

  function automatic logic [7:0] status_byte(input logic vsync_l, input logic display_enable);
    return {STATUS_HI, vsync_l, STATUS_MID, ~display_enable};
  endfunction

endpackage

// File: rtl/isa_video_regs_if.sv
// ISA bus signal bundle seen by the video register block; the adapter is
// the slave, the bus (or a bench) is the master.
interface isa_video_regs_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] bus_a;
  logic              bus_ior_l;
  logic              bus_iow_l;
  logic              bus_memr_l;
  logic              bus_memw_l;
  logic              bus_mem_cs;
  logic              bus_aen;
  logic [7:0]        bus_d;
  logic [7:0]        bus_out;
  logic              bus_dir;
  logic              bus_rdy;

  modport master (
    output bus_a, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_mem_cs, bus_aen, bus_d,
    input  bus_out, bus_dir, bus_rdy
  );

  modport slave (
    input  bus_a, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_mem_cs, bus_aen, bus_d,
    output bus_out, bus_dir, bus_rdy
  );
endinterface

// File: rtl/isa_wait_gen.sv
// Memory wait-state generator: holds bus_rdy low from a framebuffer access
// until the pixel sequencer reaches WAIT_END, or a timeout expires.
`ifdef ISA_WAIT_STATE_EN
module isa_wait_gen
  import isa_video_regs_pkg::*;
#(
  parameter logic [4:0] WAIT_START = 5'd17,
  parameter logic [4:0] WAIT_END   = 5'd20,
  parameter logic [5:0] WAIT_MAX   = 6'd40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       memsel,
  input  logic [4:0] clk_seq,
  output logic       bus_rdy
);

  wait_state_e state_reg, state_next;
  logic [5:0]  tmo_reg, tmo_next;
  logic        tmo_hit;

  assign tmo_hit = (tmo_reg == WAIT_MAX - 6'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= WS_IDLE;
      tmo_reg   <= 6'd0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    bus_rdy    = 1'b1;
    case (state_reg)
      WS_IDLE: begin
        tmo_next = 6'd0;
        if (memsel) state_next = WS_W1;
      end
      WS_W1: begin
        bus_rdy  = 1'b0;
        tmo_next = tmo_reg + 6'd1;
        if (!memsel)                     state_next = WS_IDLE;
        else if (tmo_hit)                state_next = WS_DONE;
        else if (clk_seq == WAIT_START)  state_next = WS_W2;
      end
      WS_W2: begin
        bus_rdy  = 1'b0;
        tmo_next = tmo_reg + 6'd1;
        if (!memsel)                               state_next = WS_IDLE;
        else if (tmo_hit || clk_seq == WAIT_END)   state_next = WS_DONE;
      end
      WS_DONE: begin
        // Stay released until the CPU finishes the access
        if (!memsel) state_next = WS_IDLE;
      end
      default: state_next = WS_IDLE;
    endcase
  end

endmodule
`endif

// File: rtl/isa_video_regs.sv
// ISA register front end for CGA/Tandy-class video: I/O decode, mode/colour/
// indexed registers, palette port, read-back mux and blink clock.
// Memory wait states are built only when ISA_WAIT_STATE_EN is defined.
module isa_video_regs
  import isa_video_regs_pkg::*;
#(
  parameter logic [15:0] IO_BASE_ADDR = 16'h3D0,
  parameter int          ADDR_W       = 15,
  parameter int          PAL_ENTRIES  = 16,
  parameter int          PAL_W        = 4,
  parameter logic [7:0]  CTRL_RESET   = 8'h29,
  parameter logic [23:0] BLINK_MAX    = 24'd0,
  parameter logic [4:0]  WAIT_START   = 5'd17,
  parameter logic [4:0]  WAIT_END     = 5'd20,
  parameter logic [5:0]  WAIT_MAX     = 6'd40
) (
  input  logic                           clk,
  input  logic                           reset,
  isa_video_regs_if.slave                bus,
  input  logic [4:0]                     clk_seq,
  input  logic                           vsync_l,
  input  logic                           display_enable,
  output logic                           crtc_cs,
  input  logic [7:0]                     crtc_rd_data,
  output logic                           crtc_write,
  output logic                           crtc_read,
  output logic [7:0]                     control_reg,
  output logic [7:0]                     color_reg,
  output logic                           pal_we,
  output logic [$clog2(PAL_ENTRIES)-1:0] pal_idx,
  output logic [PAL_W-1:0]               pal_data,
  output logic [PAL_W-1:0]               border_col,
  input  logic                           blink_hold,
  output logic                           blink
);

  localparam int                PIDX_W = $clog2(PAL_ENTRIES);
  localparam logic [ADDR_W-1:0] BASE   = IO_BASE_ADDR[ADDR_W-1:0];

  logic [3:0] offset;
  logic       io_hit, status_hit;

  assign offset     = bus.bus_a[3:0];
  assign io_hit     = (bus.bus_a[ADDR_W-1:4] == BASE[ADDR_W-1:4]) & ~bus.bus_aen;
  assign crtc_cs    = (bus.bus_a[ADDR_W-1:3] == BASE[ADDR_W-1:3]) & ~bus.bus_aen;
  assign status_hit = io_hit & (offset == OFS_INDEX);

  // Read path works from the raw strobe so data is on the bus for the whole cycle
  always_comb begin
    bus.bus_out = 8'h00;
    if (status_hit)
      bus.bus_out = status_byte(vsync_l, display_enable);
    else if (crtc_cs & bus.bus_a[0])
      bus.bus_out = crtc_rd_data;
  end

  assign bus.bus_dir = (crtc_cs | status_hit) & ~bus.bus_ior_l;

  // Index 0 = ior, 1 = iow; third stage only feeds the falling-edge detector
  logic [1:0] strobe_raw, strobe_s2, strobe_s3;
  assign strobe_raw = {bus.bus_iow_l, bus.bus_ior_l};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic [2:0] chain_reg;
      always_ff @(posedge clk) begin
        if (reset) chain_reg <= 3'b111;
        else       chain_reg <= {chain_reg[1:0], strobe_raw[gi]};
      end
      assign strobe_s2[gi] = chain_reg[1];
      assign strobe_s3[gi] = chain_reg[2];
    end
  endgenerate

  logic write_evt;
  assign write_evt = ~strobe_s2[1] & strobe_s3[1];
  assign crtc_read = ~strobe_s2[0];

  logic [4:0] idx_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      control_reg <= CTRL_RESET;
      color_reg   <= 8'h00;
      idx_reg     <= 5'd0;
      border_col  <= '0;
      pal_we      <= 1'b0;
      pal_idx     <= '0;
      pal_data    <= '0;
      crtc_write  <= 1'b0;
    end else begin
      crtc_write <= 1'b0;
      pal_we     <= 1'b0;
      if (write_evt) begin
        if (crtc_cs) crtc_write <= 1'b1;
        if (io_hit) begin
          case (offset)
            OFS_CONTROL: control_reg <= bus.bus_d;
            OFS_COLOR:   color_reg   <= bus.bus_d;
            OFS_INDEX:   idx_reg     <= bus.bus_d[4:0];
            OFS_DATA: begin
              if (idx_reg[4]) begin
                pal_we   <= 1'b1;
                pal_idx  <= idx_reg[PIDX_W-1:0];
                pal_data <= bus.bus_d[PAL_W-1:0];
              end else if (idx_reg[3:0] == IDX_BORDER) begin
                border_col <= bus.bus_d[PAL_W-1:0];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  logic [23:0] blink_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_reg <= 24'd0;
      blink         <= 1'b0;
    end else if (!blink_hold) begin
      if (blink_cnt_reg == BLINK_MAX) begin
        blink_cnt_reg <= 24'd0;
        blink         <= ~blink;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 24'd1;
      end
    end
  end

  logic sync_unused;
  assign sync_unused = strobe_s3[0];

`ifdef ISA_WAIT_STATE_EN
  logic memsel;
  assign memsel = bus.bus_mem_cs & ~bus.bus_aen & (~bus.bus_memr_l | ~bus.bus_memw_l);

  isa_wait_gen #(
    .WAIT_START (WAIT_START),
    .WAIT_END   (WAIT_END),
    .WAIT_MAX   (WAIT_MAX)
  ) u_wait_gen (
    .clk     (clk),
    .reset   (reset),
    .memsel  (memsel),
    .clk_seq (clk_seq),
    .bus_rdy (bus.bus_rdy)
  );
`else
  assign bus.bus_rdy = 1'b1;

  logic wait_unused;
  assign wait_unused = ^{clk_seq, bus.bus_memr_l, bus.bus_memw_l, bus.bus_mem_cs};
`endif

endmodule

// File: tb/tb_isa_video_regs.sv
// Scoreboard bench for isa_video_regs: stimulus queues expected values,
// a negedge monitor compares them and checks every palette write pulse.
module tb_isa_video_regs;

  localparam int ADDR_W = 15;

  localparam int S_CONTROL = 0;
  localparam int S_COLOR   = 1;
  localparam int S_BORDER  = 2;
  localparam int S_OUT     = 3;
  localparam int S_DIR     = 4;
  localparam int S_RDY     = 5;
  localparam int S_BLINK   = 6;
  localparam int S_CS      = 7;
  localparam int S_CREAD   = 8;
  localparam int S_PALWE   = 9;
  localparam int S_NPAL    = 10;
  localparam int S_NCRTC   = 11;
  localparam int S_PALQ    = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] clk_seq;
  logic       vsync_l, display_enable;
  logic       crtc_cs;
  logic [7:0] crtc_rd_data;
  logic       crtc_write, crtc_read;
  logic [7:0] control_reg, color_reg;
  logic       pal_we;
  logic [3:0] pal_idx, pal_data, border_col;
  logic       blink_hold, blink;

  always #5 clk = ~clk;

  isa_video_regs_if #(.ADDR_W(ADDR_W)) bus ();

  isa_video_regs #(
    .BLINK_MAX (24'd3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .clk_seq        (clk_seq),
    .vsync_l        (vsync_l),
    .display_enable (display_enable),
    .crtc_cs        (crtc_cs),
    .crtc_rd_data   (crtc_rd_data),
    .crtc_write     (crtc_write),
    .crtc_read      (crtc_read),
    .control_reg    (control_reg),
    .color_reg      (color_reg),
    .pal_we         (pal_we),
    .pal_idx        (pal_idx),
    .pal_data       (pal_data),
    .border_col     (border_col),
    .blink_hold     (blink_hold),
    .blink          (blink)
  );

  int         sel_q[$];
  logic [7:0] exp_q[$];
  string      name_q[$];
  logic [7:0] pal_q[$];

  int   n_chk = 0;
  int   n_bad = 0;
  int   n_pal = 0;
  int   n_crtc = 0;
  int   m_cnt;
  logic m_blink;
  logic seq_run;

  function automatic logic [7:0] sample(input int sel);
    case (sel)
      S_CONTROL: return control_reg;
      S_COLOR:   return color_reg;
      S_BORDER:  return {4'h0, border_col};
      S_OUT:     return bus.bus_out;
      S_DIR:     return {7'h0, bus.bus_dir};
      S_RDY:     return {7'h0, bus.bus_rdy};
      S_BLINK:   return {7'h0, blink};
      S_CS:      return {7'h0, crtc_cs};
      S_CREAD:   return {7'h0, crtc_read};
      S_PALWE:   return {7'h0, pal_we};
      S_NPAL:    return n_pal[7:0];
      S_NCRTC:   return n_crtc[7:0];
      S_PALQ:    return 8'(pal_q.size());
      default:   return 8'hEE;
    endcase
  endfunction

  always @(negedge clk) begin
    int         sel;
    logic [7:0] exp_v, act, pexp;
    string      nm;
    while (sel_q.size() > 0) begin
      sel   = sel_q.pop_front();
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act   = sample(sel);
      n_chk++;
      if (act !== exp_v) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", nm, act, exp_v);
      end else begin
        $display("check %s: %h ok", nm, act);
      end
    end
    if (pal_we === 1'b1) begin
      n_pal++;
      n_chk++;
      if (pal_q.size() == 0) begin
        n_bad++;
        $display("FAIL pal_unexpected: got idx=%h data=%h want no write", pal_idx, pal_data);
      end else begin
        pexp = pal_q.pop_front();
        if ({pal_idx, pal_data} !== pexp) begin
          n_bad++;
          $display("FAIL pal_write: got %h want %h", {pal_idx, pal_data}, pexp);
        end else begin
          $display("check pal_write: %h ok", pexp);
        end
      end
    end
    if (crtc_write === 1'b1) n_crtc++;
  end

  task automatic exp_chk(input int sel, input logic [7:0] v, input string nm);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  // One clock; the blink model follows the inputs the DUT sampled on this edge
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_cnt   = 0;
      m_blink = 1'b0;
    end else if (!blink_hold) begin
      if (m_cnt == 3) begin
        m_cnt   = 0;
        m_blink = ~m_blink;
      end else begin
        m_cnt++;
      end
    end
    #1;
    if (seq_run) clk_seq = clk_seq + 5'd1;
  endtask

  task automatic io_write(input logic [14:0] a, input logic [7:0] d);
    bus.bus_a     = a;
    bus.bus_d     = d;
    bus.bus_iow_l = 1'b0;
    repeat (10) step();
    bus.bus_iow_l = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    reset          = 1'b1;
    bus.bus_a      = '0;
    bus.bus_d      = 8'h00;
    bus.bus_ior_l  = 1'b1;
    bus.bus_iow_l  = 1'b1;
    bus.bus_memr_l = 1'b1;
    bus.bus_memw_l = 1'b1;
    bus.bus_mem_cs = 1'b0;
    bus.bus_aen    = 1'b0;
    clk_seq        = 5'd0;
    vsync_l        = 1'b1;
    display_enable = 1'b0;
    crtc_rd_data   = 8'h5A;
    blink_hold     = 1'b0;
    seq_run        = 1'b1;
    m_cnt          = 0;
    m_blink        = 1'b0;

    repeat (3) step();
    exp_chk(S_CONTROL, 8'h29, "reset_control");
    exp_chk(S_COLOR,   8'h00, "reset_color");
    exp_chk(S_BORDER,  8'h00, "reset_border");
    exp_chk(S_BLINK,   8'h00, "reset_blink");
    exp_chk(S_RDY,     8'h01, "reset_rdy");
    exp_chk(S_DIR,     8'h00, "reset_dir");
    exp_chk(S_PALWE,   8'h00, "reset_pal_we");
    step();
    reset = 1'b0;

    // Commit lands on the third edge after iow_l falls
    bus.bus_a = 15'h3D8; bus.bus_d = 8'h1A; bus.bus_iow_l = 1'b0;
    step(); step();
    exp_chk(S_CONTROL, 8'h29, "commit_not_early");
    step();
    exp_chk(S_CONTROL, 8'h1A, "commit_edge3");
    repeat (7) step();
    bus.bus_iow_l = 1'b1;
    repeat (4) step();
    exp_chk(S_COLOR,  8'h00, "color_untouched");
    exp_chk(S_BORDER, 8'h00, "border_untouched");

    io_write(15'h3D9, 8'h5C);
    exp_chk(S_COLOR,   8'h5C, "color_write");
    exp_chk(S_CONTROL, 8'h1A, "control_kept");

    io_write(15'h3D4, 8'h0E);
    exp_chk(S_NCRTC, 8'd1, "crtc_write_single");

    io_write(15'h3DA, 8'h13);
    pal_q.push_back(8'h3C);
    io_write(15'h3DE, 8'h0C);
    exp_chk(S_NPAL, 8'd1, "pal_single_pulse");
    exp_chk(S_PALQ, 8'd0, "pal_seen");

    io_write(15'h3DA, 8'h02);
    io_write(15'h3DE, 8'h05);
    exp_chk(S_BORDER, 8'h05, "border_write");

    io_write(15'h3DA, 8'h07);
    io_write(15'h3DE, 8'h09);
    exp_chk(S_BORDER, 8'h05, "idx7_ignored");
    exp_chk(S_NPAL,   8'd1,  "idx7_no_pal");

    io_write(15'h3DA, 8'h1F);
    pal_q.push_back(8'hF7);
    io_write(15'h3DE, 8'hA7);
    exp_chk(S_NPAL, 8'd2, "pal_idx15");
    exp_chk(S_PALQ, 8'd0, "pal_idx15_seen");

    io_write(15'h3DB, 8'hFF);
    exp_chk(S_CONTROL, 8'h1A, "unmapped_control");
    exp_chk(S_COLOR,   8'h5C, "unmapped_color");

    bus.bus_aen = 1'b1;
    io_write(15'h3D8, 8'h00);
    io_write(15'h3D4, 8'h11);
    bus.bus_aen = 1'b0;
    exp_chk(S_CONTROL, 8'h1A, "aen_blocks_write");
    exp_chk(S_NCRTC,   8'd1,  "aen_blocks_crtc");

    bus.bus_a = 15'h3DA; vsync_l = 1'b0; display_enable = 1'b1; bus.bus_ior_l = 1'b0;
    exp_chk(S_OUT, 8'hF4, "status_vs0_de1");
    exp_chk(S_DIR, 8'h01, "status_dir");
    step();
    vsync_l = 1'b1; display_enable = 1'b0;
    exp_chk(S_OUT, 8'hFD, "status_vs1_de0");
    step();
    bus.bus_aen = 1'b1;
    exp_chk(S_DIR, 8'h00, "status_aen_dir");
    exp_chk(S_OUT, 8'h00, "status_aen_out");
    step();
    bus.bus_aen = 1'b0;
    bus.bus_a = 15'h3D5;
    exp_chk(S_OUT, 8'h5A, "crtc_odd_read");
    exp_chk(S_DIR, 8'h01, "crtc_odd_dir");
    exp_chk(S_CS,  8'h01, "crtc_cs_hit");
    step(); step();
    exp_chk(S_CREAD, 8'h01, "crtc_read_sync");
    step();
    bus.bus_aen = 1'b1;
    exp_chk(S_CS,  8'h00, "crtc_cs_aen");
    exp_chk(S_DIR, 8'h00, "crtc_dir_aen");
    step();
    bus.bus_aen = 1'b0;
    bus.bus_a = 15'h3D4;
    exp_chk(S_OUT, 8'h00, "crtc_even_read");
    exp_chk(S_DIR, 8'h01, "crtc_even_dir");
    step();
    bus.bus_a = 15'h3D8;
    exp_chk(S_DIR, 8'h00, "ctrl_no_drive");
    step();
    bus.bus_a = 15'h3D5; bus.bus_ior_l = 1'b1;
    exp_chk(S_DIR, 8'h00, "dir_ior_high");
    repeat (3) step();
    exp_chk(S_CREAD, 8'h00, "crtc_read_drop");

    bus.bus_a = 15'h3D5; bus.bus_d = 8'h33; bus.bus_ior_l = 1'b0; bus.bus_iow_l = 1'b0;
    exp_chk(S_OUT, 8'h5A, "rw_overlap_read");
    repeat (10) step();
    bus.bus_iow_l = 1'b1; bus.bus_ior_l = 1'b1;
    repeat (4) step();
    exp_chk(S_NCRTC, 8'd2, "rw_overlap_write");

    for (int i = 0; i < 10; i++) begin
      exp_chk(S_BLINK, {7'h0, m_blink}, "blink_run");
      step();
    end
    blink_hold = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      exp_chk(S_BLINK, {7'h0, m_blink}, "blink_hold");
      step();
    end
    blink_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_chk(S_BLINK, {7'h0, m_blink}, "blink_resume");
    end

`ifdef ISA_WAIT_STATE_EN
    seq_run = 1'b1;
    for (int g = 0; g < 64 && clk_seq != 5'd3; g++) step();
    bus.bus_mem_cs = 1'b1; bus.bus_memr_l = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_chk(S_RDY, (clk_seq >= 5'd4 && clk_seq <= 5'd20) ? 8'h00 : 8'h01, "wait_seq");
    end
    bus.bus_memr_l = 1'b1;
    step();
    exp_chk(S_RDY, 8'h01, "wait_idle");
    seq_run = 1'b0; clk_seq = 5'd5;
    step();
    bus.bus_memr_l = 1'b0;
    for (int i = 1; i <= 41; i++) begin
      step();
      exp_chk(S_RDY, (i <= 40) ? 8'h00 : 8'h01, "wait_timeout");
    end
    bus.bus_memr_l = 1'b1;
    step(); step();
`else
    bus.bus_mem_cs = 1'b1; bus.bus_memr_l = 1'b0;
    repeat (3) begin
      step();
      exp_chk(S_RDY, 8'h01, "rdy_tied");
    end
    bus.bus_memr_l = 1'b1;
    step();
`endif

    seq_run = 1'b0; clk_seq = 5'd5;
    bus.bus_mem_cs = 1'b1; bus.bus_memr_l = 1'b0;
    repeat (3) step();
`ifdef ISA_WAIT_STATE_EN
    exp_chk(S_RDY, 8'h00, "mid_wait_low");
`else
    exp_chk(S_RDY, 8'h01, "mid_wait_high");
`endif
    reset = 1'b1;
    step();
    exp_chk(S_RDY,     8'h01, "rst_mid_rdy");
    exp_chk(S_CONTROL, 8'h29, "rst_mid_control");
    exp_chk(S_COLOR,   8'h00, "rst_mid_color");
    exp_chk(S_BORDER,  8'h00, "rst_mid_border");
    exp_chk(S_BLINK,   8'h00, "rst_mid_blink");
    exp_chk(S_PALWE,   8'h00, "rst_mid_pal_we");
    step();
    bus.bus_memr_l = 1'b1; bus.bus_mem_cs = 1'b0;
    reset = 1'b0;
    step(); step();
    exp_chk(S_PALQ,  8'd0, "final_pal_queue");
    exp_chk(S_NCRTC, 8'd2, "final_crtc_count");
    step(); step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
